// File: rtl/axis_rr_packet_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_packet_arbiter
// Packet-level round-robin arbiter sharing one valid/ready stream between
// N_SRC upstream AXI-stream sources. The grant is locked from the first beat
// of a packet until its last beat is accepted, so packets never interleave.
// Only arbitration state is registered; the data path is a combinational mux.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   valid_in      : per-source valid (bit i = source i)
//   data_in       : per-source data, source i at [i*DATA_WD +: DATA_WD]
//   keep_in       : per-source byte keep, sliced like data_in
//   last_in       : per-source end-of-packet
//   ready_in      : per-source ready (only the granted source sees ready_out)
//   valid_out     : downstream valid
//   data_out      : granted source data
//   keep_out      : granted source keep
//   last_out      : granted source last
//   ready_out     : downstream ready
//   grant_o       : registered one-hot grant, zero when idle
//   busy_o        : registered, high while a packet is locked
// ---------------------------------------------------------------------------
module axis_rr_packet_arbiter #(
    parameter int unsigned N_SRC        = 4,
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_SRC-1:0]                valid_in,
    input  logic [N_SRC*DATA_WD-1:0]        data_in,
    input  logic [N_SRC*DATA_BYTE_WD-1:0]   keep_in,
    input  logic [N_SRC-1:0]                last_in,
    output logic [N_SRC-1:0]                ready_in,
    output logic                            valid_out,
    output logic [DATA_WD-1:0]              data_out,
    output logic [DATA_BYTE_WD-1:0]         keep_out,
    output logic                            last_out,
    input  logic                            ready_out,
    output logic [N_SRC-1:0]                grant_o,
    output logic                            busy_o
);

    localparam int unsigned IDX_WD = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [N_SRC-1:0]    grant_q, grant_d;
    logic [IDX_WD-1:0]   gidx_q,  gidx_d;
    logic [IDX_WD-1:0]   ptr_q,   ptr_d;
    logic                busy_q,  busy_d;

    logic                req_found;
    logic [IDX_WD-1:0]   req_idx;
    int unsigned         cand;

    logic                sel_valid;
    logic [DATA_WD-1:0]  sel_data;
    logic [DATA_BYTE_WD-1:0] sel_keep;
    logic                sel_last;
    logic                xfer_last;
    logic [IDX_WD-1:0]   ptr_next;

    // Round-robin search: first requester scanning upward from ptr with wrap
    always_comb begin
        req_found = 1'b0;
        req_idx   = ptr_q;
        cand      = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= N_SRC) begin
                cand = cand - N_SRC;
            end
            if (!req_found && valid_in[IDX_WD'(cand)]) begin
                req_found = 1'b1;
                req_idx   = IDX_WD'(cand);
            end
        end
    end

    // Select the locked source's slice
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (gidx_q == IDX_WD'(i)) begin
                sel_valid = valid_in[i];
                sel_data  = data_in[i*DATA_WD +: DATA_WD];
                sel_keep  = keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                sel_last  = last_in[i];
            end
        end
    end

    // Datapath outputs are forced to zero outside LOCK (covers reset too)
    always_comb begin
        valid_out = 1'b0;
        data_out  = '0;
        keep_out  = '0;
        last_out  = 1'b0;
        ready_in  = '0;
        if (state_q == LOCK) begin
            valid_out = sel_valid;
            data_out  = sel_data;
            keep_out  = sel_keep;
            last_out  = sel_last;
            ready_in  = grant_q & {N_SRC{ready_out}};
        end
    end

    assign xfer_last = (state_q == LOCK) && sel_valid && ready_out && sel_last;
    assign ptr_next  = (gidx_q == IDX_WD'(N_SRC - 1)) ? '0 : gidx_q + IDX_WD'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d = LOCK;
                    grant_d = N_SRC'(1) << req_idx;
                    gidx_d  = req_idx;
                    busy_d  = 1'b1;
                end
            end
            LOCK: begin
                if (xfer_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
Packet-level round-robin arbiter that shares one downstream valid/ready stream between N_SRC upstream AXI-stream sources. It sits in front of the header-insert datapath's buffered (bypass-FIFO) input chain. It locks the grant to one source from the first beat of a packet until that packet's last beat is accepted, so packets are never interleaved. It registers arbitration state only; the data path through the block is a combinational mux.

Parameters:
N_SRC, 4, number of requesting sources; legal range 2..16.
DATA_WD, 32, data width per beat in bits; must be a multiple of 8.
DATA_BYTE_WD, DATA_WD/8, keep width per beat.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
valid_in  input  N_SRC  per-source valid; bit i belongs to source i
data_in  input  N_SRC*DATA_WD  per-source data; source i occupies slice [i*DATA_WD +: DATA_WD]
keep_in  input  N_SRC*DATA_BYTE_WD  per-source byte keep, sliced the same way as data_in
last_in  input  N_SRC  per-source end-of-packet flag
ready_in  output  N_SRC  per-source ready
valid_out  output  1  valid to the downstream stage
data_out  output  DATA_WD  data of the granted source
keep_out  output  DATA_BYTE_WD  keep of the granted source
last_out  output  1  last of the granted source
ready_out  input  1  ready from the downstream stage
grant_o  output  N_SRC  registered one-hot grant; all zeros when idle
busy_o  output  1  high while in the LOCK state

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst_n is asynchronous and active-low; assertion forces reset values immediately. Reset values: state=IDLE, grant_o=0, ptr=0, busy_o=0. All datapath outputs resolve to 0 during reset: valid_out=0, ready_in=0, data_out=0, keep_out=0, last_out=0.
- State machine, IDLE:
  - ready_in=0 and valid_out=0.
  - If any valid_in bit is high, pick the first requester found by scanning upward from ptr with wrap-around (ptr, ptr+1, ..., N_SRC-1, 0, ..., ptr-1).
  - The winner's bit is set in grant_o on the next clock edge and the state moves to LOCK.
  - If no valid_in bit is high, stay in IDLE.
- State machine, LOCK (granted source g):
  - valid_out=valid_in[g], data_out, keep_out and last_out come from slice g, ready_in[g]=ready_out, and all other ready_in bits are 0.
  - A beat transfers when valid_out and ready_out are both high.
  - A transfer with last_out=1 moves the state to IDLE, sets ptr to (g+1) mod N_SRC, and clears grant_o on the same edge.
  - A transfer with last_out=0 keeps the state in LOCK.
  - valid_in[g] dropping mid-packet does not release the grant; the arbiter waits for source g.
- Latency and throughput:
  - One cycle from first valid_in assertion in IDLE to valid_out.
  - One idle bubble cycle after every packet, so the minimum per-packet overhead is 1 cycle.
  - Data latency in LOCK is 0 cycles (combinational mux).
- Fairness: any continuously requesting source is granted within N_SRC-1 packets of other sources.
- Single-beat packets: a first beat with last=1 is accepted and returns the arbiter to IDLE in the same handshake cycle.
- Simultaneous events:
  - New requests that arrive during LOCK are ignored until IDLE.
  - A source whose valid drops in IDLE before the grant edge is not selected.
  - If valid_in[g] is already low when LOCK begins, valid_out=0 until source g re-asserts.
- Reset asserted mid-packet: the grant is dropped immediately and no beat is transferred in that cycle. After reset releases, arbitration restarts from ptr=0.
- Protocol rules:
  - data_out, keep_out and last_out are don't-care while valid_out=0; the bench must not check them.
  - Upstream must hold data stable while valid_in is high and ready_in is low.

Test Plan:
- Reset check: rst_n=0 with all valid_in=1 -> valid_out=0, ready_in=0, grant_o=0, busy_o=0. Release reset -> grant_o=0001 after one clock, then valid_out=1.
- Round-robin order: sources 0..3 each continuously send 2-beat packets -> packet order on the output is 0,1,2,3,0. grant_o steps 0001, 0010, 0100, 1000 with exactly one bubble cycle between packets.
- No interleaving: source 1 sends a 5-beat packet; source 0 asserts valid at beat 2 -> all 5 beats come from source 1 contiguously, then ptr=2, so source 0 is granted next (the scan wraps 2→3→0).
- Backpressure: ready_out toggles 1,0,0,1 during a 3-beat packet from source 2 -> data_out holds while stalled, ready_in=0100 mirrors ready_out, and no beat is lost or duplicated.
- Single-beat packets: source 3 sends 4 back-to-back 1-beat packets alone -> each beat is accepted every 2 cycles and grant_o alternates between 1000 and 0000.
- Mid-packet reset: assert rst_n=0 during beat 2 of a 4-beat packet -> valid_out=0 immediately. After release, the first grant goes to the lowest requesting index at or above 0.
